// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides, optional 1-entry skid buffer
// (SKID_EN) and flush. Define DECODE_RV32M_EN to accept M-extension ALU ops (funct7=0000001).
module decode_stage #(
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [31:0]     o_imm,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [3:0]      o_alu_op,
  output logic            o_rs1_pc,
  output logic            o_rs2_imm,
  output logic            o_branch,
  output logic [2:0]      o_branch_type,
  output logic            o_jump,
  output logic [1:0]      o_loadstore,
  output logic            o_load_zext,
  output logic            o_illegal,
  output logic            o_muldiv
);
  // Handshake: a word moves on an edge where valid & ready are both high on that side;
  // the producer holds valid and data stable until then, ready never depends on i_flush.

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [3:0]      alu_op;
    logic            rs1_pc;
    logic            rs2_imm;
    logic            branch;
    logic [2:0]      branch_type;
    logic            jump;
    logic [1:0]      loadstore;
    logic            load_zext;
    logic            illegal;
    logic            muldiv;
  } dec_t;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t        dec, out_q, skid_q;
  logic        out_valid, skid_full, ready_q, accept;

  assign op    = i_instr[6:0];
  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.pc      = i_pc;
    dec.rd      = i_instr[11:7];
    dec.rs1     = i_instr[19:15];
    dec.rs2     = i_instr[24:20];
    dec.rs2_imm = (op != OP_ALU);
    unique case (op)
      OP_LUI:   begin dec.imm = imm_u; dec.rs1 = '0; end
      OP_AUIPC: begin dec.imm = imm_u; dec.rs1_pc = 1'b1; end
      OP_JAL:   begin dec.imm = imm_j; dec.rs1_pc = 1'b1; dec.jump = 1'b1; end
      OP_JALR: begin
        dec.imm = imm_i; dec.rs1_pc = 1'b1; dec.jump = 1'b1;
        dec.illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        dec.imm = imm_b; dec.rs1_pc = 1'b1; dec.branch = 1'b1;
        dec.branch_type = f3; dec.rd = '0;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        dec.imm = imm_i; dec.loadstore = f3[1:0] + 2'd1; dec.load_zext = f3[2];
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.imm = imm_s; dec.loadstore = f3[1:0] + 2'd1; dec.rd = '0;
        dec.illegal = (f3 > 3'b010);
      end
      OP_ALUIMM: begin
        dec.imm    = imm_i;
        dec.alu_op = {(f3 == 3'b101) ? i_instr[30] : 1'b0, f3};
        // Shift immediates reuse funct7 as an encoding field; anything else there is reserved.
        dec.illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                      ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      OP_ALU: begin
        dec.alu_op = {i_instr[30], f3};
        if (f7 == 7'b0100000) begin
          dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
        end else if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
          dec.muldiv = 1'b1;
          dec.alu_op = {1'b0, f3};
`else
          dec.illegal = 1'b1;
`endif
        end else if (f7 != 7'b0000000) begin
          dec.illegal = 1'b1;
        end
      end
      OP_FENCE, OP_SYSTEM: dec.imm = imm_i;
      default: dec.illegal = 1'b1;
    endcase
    // Illegal words still flow to execute (which traps), but must have no side effects.
    if (dec.illegal) begin
      dec.rd          = '0;
      dec.branch      = 1'b0;
      dec.branch_type = '0;
      dec.jump        = 1'b0;
      dec.loadstore   = '0;
      dec.muldiv      = 1'b0;
    end
  end

  assign o_ready = SKID_EN ? ready_q : (!out_valid || i_ready);
  assign accept  = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q     <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      ready_q   <= 1'b1;
    end else if (i_flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      ready_q   <= 1'b1;
    end else if (!out_valid || i_ready) begin
      if (skid_full) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
        ready_q   <= 1'b1;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Output is stalled; only reachable with the skid buffer enabled.
      skid_q    <= dec;
      skid_full <= 1'b1;
      ready_q   <= 1'b0;
    end
  end

  assign o_valid       = out_valid;
  assign o_pc          = out_q.pc;
  assign o_imm         = out_q.imm;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_alu_op      = out_q.alu_op;
  assign o_rs1_pc      = out_q.rs1_pc;
  assign o_rs2_imm     = out_q.rs2_imm;
  assign o_branch      = out_q.branch;
  assign o_branch_type = out_q.branch_type;
  assign o_jump        = out_q.jump;
  assign o_loadstore   = out_q.loadstore;
  assign o_load_zext   = out_q.load_zext;
  assign o_illegal     = out_q.illegal;
  assign o_muldiv      = out_q.muldiv;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written stall/flush/reset sequences,
// and randomized traffic checked against a 2-deep queue model with a reference decoder.
module tb_decode_stage;
  localparam int PC_W = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n, i_valid, o_ready, i_flush, o_valid, i_ready;
  logic [31:0]     i_instr, o_imm;
  logic [PC_W-1:0] i_pc, o_pc;
  logic [4:0]      o_rd, o_rs1, o_rs2;
  logic [3:0]      o_alu_op;
  logic            o_rs1_pc, o_rs2_imm, o_branch, o_jump, o_load_zext, o_illegal, o_muldiv;
  logic [2:0]      o_branch_type;
  logic [1:0]      o_loadstore;

  always #5 i_clk = ~i_clk;

  decode_stage #(.PC_W(PC_W), .SKID_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_imm(o_imm), .o_rd(o_rd), .o_rs1(o_rs1),
    .o_rs2(o_rs2), .o_alu_op(o_alu_op), .o_rs1_pc(o_rs1_pc), .o_rs2_imm(o_rs2_imm),
    .o_branch(o_branch), .o_branch_type(o_branch_type), .o_jump(o_jump),
    .o_loadstore(o_loadstore), .o_load_zext(o_load_zext), .o_illegal(o_illegal),
    .o_muldiv(o_muldiv)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu_op;
    logic        rs1_pc, rs2_imm, branch;
    logic [2:0]  branch_type;
    logic        jump;
    logic [1:0]  loadstore;
    logic        load_zext, illegal, muldiv;
  } dec_t;

  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [4:0]  rd, rs1;
    logic [3:0]  alu_op;
    logic        rs1_pc, rs2_imm, branch, jump;
    logic [1:0]  ls;
    logic        illegal, muldiv;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  dec_t exp_q[$];
  dec_t hold;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic dec_t dut_fields();
    dec_t d;
    d = '{pc: o_pc, imm: o_imm, rd: o_rd, rs1: o_rs1, rs2: o_rs2, alu_op: o_alu_op,
          rs1_pc: o_rs1_pc, rs2_imm: o_rs2_imm, branch: o_branch, branch_type: o_branch_type,
          jump: o_jump, loadstore: o_loadstore, load_zext: o_load_zext, illegal: o_illegal,
          muldiv: o_muldiv};
    return d;
  endfunction

  // Reference decoder: immediates built with signed arithmetic, legality from encoding sets.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ill;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    ill = 1'b0;
    d = '0;
    d.pc = pc; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
    d.rs2_imm = (op != 7'h33);
    case (op)
      7'h37: begin d.imm = {ins[31:12], 12'h000}; d.rs1 = 5'd0; end
      7'h17: begin d.imm = ins & 32'hFFFF_F000; d.rs1_pc = 1'b1; end
      7'h6f: begin
        d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        d.rs1_pc = 1'b1; d.jump = 1'b1;
      end
      7'h67: begin
        d.imm = 32'($signed(ins[31:20])); d.rs1_pc = 1'b1; d.jump = 1'b1; ill = (f3 != 0);
      end
      7'h63: begin
        d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        d.rs1_pc = 1'b1; d.branch = 1'b1; d.branch_type = f3; d.rd = 5'd0;
        ill = f3 inside {3'd2, 3'd3};
      end
      7'h03: begin
        d.imm = 32'($signed(ins[31:20])); d.loadstore = 2'(f3 % 4 + 1); d.load_zext = f3[2];
        ill = f3 inside {3'd3, 3'd6, 3'd7};
      end
      7'h23: begin
        d.imm = 32'($signed({ins[31:25], ins[11:7]})); d.loadstore = 2'(f3 % 4 + 1);
        d.rd = 5'd0; ill = (f3 > 2);
      end
      7'h13: begin
        d.imm = 32'($signed(ins[31:20]));
        d.alu_op = (f3 == 5) ? {ins[30], f3} : {1'b0, f3};
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !(f7 inside {7'h00, 7'h20});
      end
      7'h33: begin
        d.alu_op = {ins[30], f3};
        if (f7 == 7'h20) ill = !(f3 inside {3'd0, 3'd5});
        else if (f7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
          d.muldiv = 1'b1; d.alu_op = {1'b0, f3};
`else
          ill = 1'b1;
`endif
        end else if (f7 != 7'h00) ill = 1'b1;
      end
      7'h0f, 7'h73: d.imm = 32'($signed(ins[31:20]));
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d.rd = 5'd0; d.branch = 1'b0; d.branch_type = 3'd0; d.jump = 1'b0;
      d.loadstore = 2'd0; d.muldiv = 1'b0;
    end
    d.illegal = ill;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[11];
    logic [31:0] ins;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    ins = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      ins[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:25] = 7'h01;
        default: ;
      endcase
    end
    return ins;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_instr = '0; i_pc = '0;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    //                 instr         pc            imm           rd  rs1 alu  pc  imm br  jp ls  ill mul
    vecs[0] = '{32'hFFD08293, 32'h100, 32'hFFFFFFFD, 5, 1, 4'h0, 0, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{32'hFE000CE3, 32'h104, 32'hFFFFFFF8, 0, 0, 4'h0, 1, 1, 1, 0, 0, 0, 0};
    vecs[2] = '{32'h00000000, 32'h108, 32'h00000000, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0};
    vecs[3] = '{32'h0040B103, 32'h10C, 32'h00000004, 0, 1, 4'h0, 0, 1, 0, 0, 0, 1, 0};
`ifdef DECODE_RV32M_EN
    vecs[4] = '{32'h022081B3, 32'h110, 32'h00000000, 3, 1, 4'h0, 0, 0, 0, 0, 0, 0, 1};
`else
    vecs[4] = '{32'h022081B3, 32'h110, 32'h00000000, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1, 0};
`endif
    vecs[5] = '{32'h123453B7, 32'h114, 32'h12345000, 7, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0};
    vecs[6] = '{32'h403100B3, 32'h118, 32'h00000000, 1, 2, 4'h8, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{32'h00512423, 32'h11C, 32'h00000008, 0, 2, 4'h0, 0, 1, 0, 0, 3, 0, 0};
    vecs[8] = '{32'h4030D093, 32'h120, 32'h00000403, 1, 1, 4'hD, 0, 1, 0, 0, 0, 0, 0};
    vecs[9] = '{32'h010000EF, 32'h124, 32'h00000010, 1, 0, 4'h0, 1, 1, 0, 1, 0, 0, 0};

    do_reset();
    chk("reset_valid", 128'(o_valid), 128'(1'b0));
    chk("reset_ready", 128'(o_ready), 128'(1'b1));
    chk("reset_data", 128'(dut_fields()), 128'(0));

    // Directed vectors, one at a time through a free-flowing output.
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_instr = vecs[k].instr; i_pc = vecs[k].pc;
      tick();
      i_valid = 1'b0;
      chk($sformatf("vec%0d_valid", k), 128'(o_valid), 128'(1'b1));
      chk($sformatf("vec%0d_fields", k),
          128'({o_pc, o_imm, o_rd, o_rs1, o_alu_op, o_rs1_pc, o_rs2_imm, o_branch, o_jump,
                o_loadstore, o_illegal, o_muldiv}),
          128'({vecs[k].pc, vecs[k].imm, vecs[k].rd, vecs[k].rs1, vecs[k].alu_op,
                vecs[k].rs1_pc, vecs[k].rs2_imm, vecs[k].branch, vecs[k].jump, vecs[k].ls,
                vecs[k].illegal, vecs[k].muldiv}));
      tick();
      chk($sformatf("vec%0d_drain", k), 128'(o_valid), 128'(1'b0));
    end

    // Stall with three streamed words: one at output, one in skid, third refused.
    i_ready = 1'b0; i_valid = 1'b1;
    i_instr = 32'hFFD08293; i_pc = 32'h200;
    tick();
    chk("stall_first", 128'({o_valid, o_pc}), 128'({1'b1, 32'h200}));
    i_instr = 32'h403100B3; i_pc = 32'h204;
    tick();
    chk("stall_skid_ready", 128'(o_ready), 128'(1'b0));
    hold = dut_fields();
    i_instr = 32'h00512423; i_pc = 32'h208;
    tick();
    chk("stall_hold", 128'(dut_fields()), 128'(hold));
    chk("stall_ready", 128'(o_ready), 128'(1'b0));
    chk("stall_pc", 128'(o_pc), 128'(32'h200));
    i_ready = 1'b1;
    tick();
    chk("drain_skid", 128'({o_valid, o_pc, o_ready}), 128'({1'b1, 32'h204, 1'b1}));
    tick();
    chk("drain_third", 128'({o_valid, o_pc}), 128'({1'b1, 32'h208}));
    i_valid = 1'b0;
    tick();
    chk("drain_empty", 128'(o_valid), 128'(1'b0));

    // Flush with output and skid full and a word offered the same cycle.
    i_ready = 1'b0; i_valid = 1'b1; i_instr = 32'hFFD08293; i_pc = 32'h300;
    tick();
    i_pc = 32'h304;
    tick();
    chk("flush_pre_ready", 128'(o_ready), 128'(1'b0));
    i_flush = 1'b1; i_pc = 32'h308;
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    chk("flush_state", 128'({o_valid, o_ready}), 128'({1'b0, 1'b1}));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_emit", 128'(o_valid), 128'(1'b0));
    end

    // Asynchronous reset in the middle of a stall.
    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h400;
    tick();
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst", 128'({o_valid, o_ready, o_pc}), 128'({1'b0, 1'b1, 32'h0}));
    tick();
    i_rst_n = 1'b1;
    tick();

    // Randomized traffic against a queue model of output register plus skid entry.
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      logic exp_ready, acc, drn;
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_flush = ($urandom_range(0, 19) == 0);
      i_instr = rand_instr();
      i_pc    = $urandom;
      exp_ready = (exp_q.size() < 2);
      chk("rnd_ready", 128'(o_ready), 128'(exp_ready));
      chk("rnd_valid", 128'(o_valid), 128'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("rnd_fields", 128'(dut_fields()), 128'(exp_q[0]));
      acc = i_valid && exp_ready && !i_flush;
      drn = (exp_q.size() > 0) && i_ready;
      tick();
      if (i_flush) exp_q.delete();
      else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_decode(i_instr, i_pc));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
